// File: rtl/id_stage.sv
// Decode stage: splits the instruction word, reads the register file with
// writeback bypass, and inserts load-use bubbles while holding fetch.
module id_stage #(
    parameter logic [5:0]  NOP_OP       = 6'b110111,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] ins_in,
    input  logic [31:0] pc_in,
    input  logic        ins_valid,
    input  logic [4:0]  wreg_e,
    input  logic        load_e,
    input  logic [4:0]  wreg_w,
    input  logic        wen_w,
    input  logic [31:0] wdata_w,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic [5:0]  op_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [10:0] aux_out,
    output logic [31:0] imm_dpl_out,
    output logic [25:0] addr_out,
    output logic [31:0] os_out,
    output logic [31:0] ot_out,
    output logic        stall_out
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        S_IDLE,
        S_STALL
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rel_q, rel_d;
    logic [XLEN-1:0]    rf_q [NREGS];
    logic [XLEN-1:0]    rf_d [NREGS];

    logic [5:0]         op_f;
    logic               wr_en;
    logic               haz;

    // Field split; these follow ins_in even in bubble and flush slots.
    always_comb begin
        op_f        = ins_in[31:26];
        rs_out      = ins_in[25:21];
        rt_out      = ins_in[20:16];
        rd_out      = ins_in[15:11];
        aux_out     = ins_in[10:0];
        addr_out    = ins_in[25:0];
        imm_dpl_out = {{16{ins_in[15]}}, ins_in[15:0]};
        pc_out      = pc_in;
    end

    assign wr_en = wen_w && (wreg_w != 5'd0);

    // Write-through read ports; r0 is hard-wired to zero.
    always_comb begin
        os_out = '0;
        ot_out = '0;
        if (rs_out != 5'd0) begin
            os_out = (wr_en && (wreg_w == rs_out)) ? wdata_w : rf_q[rs_out];
        end
        if (rt_out != 5'd0) begin
            ot_out = (wr_en && (wreg_w == rt_out)) ? wdata_w : rf_q[rt_out];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wr_en) begin
            rf_d[wreg_w] = wdata_w;
        end
        rf_d[0] = '0;
    end

    // The release flag lets the instruction held during the bubbles issue once.
    assign haz = ins_valid && load_e && (wreg_e != 5'd0)
               && ((wreg_e == rs_out) || (wreg_e == rt_out)) && !rel_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        stall_out = 1'b0;
        op_out    = ins_valid ? op_f : NOP_OP;

        if (rstd) begin
            op_out = NOP_OP;
        end else if (flush) begin
            op_out  = NOP_OP;
            state_d = S_IDLE;
            cnt_d   = '0;
            rel_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (haz) begin
                        stall_out = 1'b1;
                        op_out    = NOP_OP;
                        cnt_d     = CNT_W'(STALL_CYCLES - 1);
                        if (STALL_CYCLES == 1) begin
                            rel_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_STALL;
                        end
                    end else begin
                        rel_d = 1'b0;
                    end
                end
                S_STALL: begin
                    stall_out = 1'b1;
                    op_out    = NOP_OP;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        rel_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: two instances (1 and 3 bubble cycles) share stimulus;
// expectations are queued per cycle and compared at the falling edge.
module tb_id_stage;

    localparam logic [5:0]  NOP     = 6'b110111;
    localparam logic [31:0] INS_LD  = 32'h8C220004;
    localparam logic [31:0] INS_ADD = 32'h20450010;

    logic        clk = 1'b0;
    logic        rstd;
    logic [31:0] ins_in, pc_in, wdata_w;
    logic        ins_valid, load_e, wen_w, flush;
    logic [4:0]  wreg_e, wreg_w;

    logic [31:0] pc1, imm1, os1, ot1, pc3, imm3, os3, ot3;
    logic [5:0]  op1, op3;
    logic [4:0]  rs1, rt1, rd1, rs3, rt3, rd3;
    logic [10:0] aux1, aux3;
    logic [25:0] addr1, addr3;
    logic        st1, st3;

    typedef enum int {P_OP1, P_ST1, P_OS1, P_OT1, P_OP3, P_ST3, P_PC,
                      P_RS, P_RT, P_RD, P_AUX, P_IMM, P_ADDR} probe_e;
    typedef struct {
        probe_e      p;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_stage #(.STALL_CYCLES(1)) dut1 (
        .clk(clk), .rstd(rstd), .ins_in(ins_in), .pc_in(pc_in), .ins_valid(ins_valid),
        .wreg_e(wreg_e), .load_e(load_e), .wreg_w(wreg_w), .wen_w(wen_w),
        .wdata_w(wdata_w), .flush(flush), .pc_out(pc1), .op_out(op1), .rs_out(rs1),
        .rt_out(rt1), .rd_out(rd1), .aux_out(aux1), .imm_dpl_out(imm1),
        .addr_out(addr1), .os_out(os1), .ot_out(ot1), .stall_out(st1)
    );

    id_stage #(.STALL_CYCLES(3)) dut3 (
        .clk(clk), .rstd(rstd), .ins_in(ins_in), .pc_in(pc_in), .ins_valid(ins_valid),
        .wreg_e(wreg_e), .load_e(load_e), .wreg_w(wreg_w), .wen_w(wen_w),
        .wdata_w(wdata_w), .flush(flush), .pc_out(pc3), .op_out(op3), .rs_out(rs3),
        .rt_out(rt3), .rd_out(rd3), .aux_out(aux3), .imm_dpl_out(imm3),
        .addr_out(addr3), .os_out(os3), .ot_out(ot3), .stall_out(st3)
    );

    function automatic logic [31:0] probe(input probe_e p);
        case (p)
            P_OP1:  return {26'd0, op1};
            P_ST1:  return {31'd0, st1};
            P_OS1:  return os1;
            P_OT1:  return ot1;
            P_OP3:  return {26'd0, op3};
            P_ST3:  return {31'd0, st3};
            P_PC:   return pc1;
            P_RS:   return {27'd0, rs1};
            P_RT:   return {27'd0, rt1};
            P_RD:   return {27'd0, rd1};
            P_AUX:  return {21'd0, aux1};
            P_IMM:  return imm1;
            P_ADDR: return {6'd0, addr1};
            default: return 32'hxxxxxxxx;
        endcase
    endfunction

    task automatic push(input probe_e p, input logic [31:0] v, input string nm);
        exp_t e;
        e.p  = p;
        e.v  = v;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic v,
                         input logic ld, input logic [4:0] we, input logic fl);
        rstd      = r;
        ins_in    = ins;
        ins_valid = v;
        load_e    = ld;
        wreg_e    = we;
        flush     = fl;
        wen_w     = 1'b0;
        wreg_w    = 5'd0;
        wdata_w   = 32'd0;
    endtask

    task automatic do_reset();
        drive(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(posedge clk); #1;
        rstd = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] got;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    drive(1'b1, INS_LD, 1'b1, 1'b1, 5'd1, 1'b0);
                    push(P_OP1, 32'(NOP), "rst_op1");
                    push(P_ST1, 32'd0, "rst_stall1");
                    push(P_OP3, 32'(NOP), "rst_op3");
                    push(P_ST3, 32'd0, "rst_stall3");
                end
                1: begin
                    drive(1'b0, 32'h20A00000, 1'b1, 1'b0, 5'd0, 1'b0);
                    wen_w = 1'b1; wreg_w = 5'd5; wdata_w = 32'hAAAA5555;
                    push(P_OS1, 32'hAAAA5555, "rst_pre_bypass_r5");
                end
                2: begin
                    drive(1'b1, 32'h20A00000, 1'b1, 1'b0, 5'd0, 1'b0);
                    push(P_OP1, 32'(NOP), "rst_again_op1");
                end
                default: begin
                    drive(1'b0, 32'h20A00000, 1'b1, 1'b0, 5'd0, 1'b0);
                    push(P_OS1, 32'd0, "rst_r5_cleared");
                    push(P_OP1, 32'h08, "rst_post_op1");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = probe(e.p); total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, i, got, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_decode();
        exp_t e;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(1'b0, 32'h2022FFFC, 1'b1, 1'b0, 5'd0, 1'b0);
                pc_in = 32'h00400010;
                push(P_OP1, 32'h08, "dec_op");
                push(P_RS, 32'd1, "dec_rs");
                push(P_RT, 32'd2, "dec_rt");
                push(P_RD, 32'd31, "dec_rd");
                push(P_AUX, 32'h7FC, "dec_aux");
                push(P_IMM, 32'hFFFFFFFC, "dec_imm_neg");
                push(P_ADDR, 32'h022FFFC, "dec_addr");
                push(P_PC, 32'h00400010, "dec_pc");
                push(P_ST1, 32'd0, "dec_stall");
            end else begin
                drive(1'b0, 32'h00007FFF, 1'b0, 1'b0, 5'd0, 1'b0);
                push(P_IMM, 32'h00007FFF, "dec_imm_pos");
                push(P_OP1, 32'(NOP), "dec_invalid_op");
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = probe(e.p); total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, i, got, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_regfile();
        exp_t e;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    drive(1'b0, 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b0);
                    wen_w = 1'b1; wreg_w = 5'd3; wdata_w = 32'hDEADBEEF;
                    push(P_OS1, 32'd0, "rf_r0_read");
                end
                1: begin
                    drive(1'b0, 32'h00640000, 1'b1, 1'b0, 5'd0, 1'b0);
                    wen_w = 1'b1; wreg_w = 5'd4; wdata_w = 32'h12345678;
                    push(P_OS1, 32'hDEADBEEF, "rf_r3_stored");
                    push(P_OT1, 32'h12345678, "rf_r4_bypass");
                end
                2: begin
                    drive(1'b0, 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b0);
                    wen_w = 1'b1; wreg_w = 5'd0; wdata_w = 32'hFFFFFFFF;
                    push(P_OS1, 32'd0, "rf_r0_no_bypass_os");
                    push(P_OT1, 32'd0, "rf_r0_no_bypass_ot");
                end
                default: begin
                    drive(1'b0, 32'h00040000, 1'b1, 1'b0, 5'd0, 1'b0);
                    push(P_OS1, 32'd0, "rf_r0_after_write");
                    push(P_OT1, 32'h12345678, "rf_r4_stored");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = probe(e.p); total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, i, got, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Single-bubble hazards, release window, rt match, r0 and invalid slots.
    task automatic test_loaduse1();
        exp_t e;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(1'b0, INS_ADD, 1'b1, 1'b1, 5'd2, 1'b0);
                1: drive(1'b0, INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
                2, 3, 4: drive(1'b0, INS_ADD, 1'b1, 1'b1, 5'd5, 1'b0);
                5: drive(1'b0, 32'h20000010, 1'b1, 1'b1, 5'd0, 1'b0);
                default: drive(1'b0, INS_ADD, 1'b0, 1'b1, 5'd2, 1'b0);
            endcase
            case (i)
                0, 2, 4: begin
                    push(P_ST1, 32'd1, "lu1_stall");
                    push(P_OP1, 32'(NOP), "lu1_bubble_op");
                end
                6: begin
                    push(P_ST1, 32'd0, "lu1_invalid_stall");
                    push(P_OP1, 32'(NOP), "lu1_invalid_op");
                end
                default: begin
                    push(P_ST1, 32'd0, "lu1_issue_stall");
                    push(P_OP1, 32'h08, "lu1_issue_op");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = probe(e.p); total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, i, got, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_loaduse3();
        exp_t e;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, INS_ADD, 1'b1, 1'b1, 5'd5, 1'b0);
            if (i == 3) begin
                push(P_ST3, 32'd0, "lu3_issue_stall");
                push(P_OP3, 32'h08, "lu3_issue_op");
            end else begin
                push(P_ST3, 32'd1, "lu3_bubble_stall");
                push(P_OP3, 32'(NOP), "lu3_bubble_op");
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = probe(e.p); total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, i, got, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    drive(1'b0, INS_ADD, 1'b1, 1'b1, 5'd2, 1'b0);
                    push(P_ST3, 32'd1, "fl_first_bubble");
                end
                1: begin
                    drive(1'b0, INS_ADD, 1'b1, 1'b1, 5'd2, 1'b1);
                    push(P_ST3, 32'd0, "fl_flush_stall");
                    push(P_OP3, 32'(NOP), "fl_flush_op");
                end
                2: begin
                    drive(1'b0, INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
                    push(P_ST3, 32'd0, "fl_idle_stall");
                    push(P_OP3, 32'h08, "fl_idle_op");
                end
                default: begin
                    drive(1'b0, INS_ADD, 1'b1, 1'b1, 5'd2, 1'b0);
                    push(P_ST3, 32'd1, "fl_new_hazard");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = probe(e.p); total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, i, got, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midstall();
        exp_t e;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1: begin
                    drive(1'b0, INS_ADD, 1'b1, 1'b1, 5'd5, 1'b0);
                    push(P_ST3, 32'd1, "rms_bubble");
                end
                2: begin
                    drive(1'b1, INS_ADD, 1'b0, 1'b1, 5'd5, 1'b0);
                    push(P_ST3, 32'd0, "rms_rst_stall");
                    push(P_OP3, 32'(NOP), "rms_rst_op");
                end
                default: begin
                    drive(1'b0, INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
                    push(P_ST3, 32'd0, "rms_after_stall");
                    push(P_OP3, 32'h08, "rms_after_op");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = probe(e.p); total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, i, got, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        pc_in = 32'h0;
        drive(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(posedge clk); #1;
        test_reset();
        test_decode();
        test_regfile();
        test_loaduse1();
        test_loaduse3();
        test_flush();
        test_reset_midstall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
